mwr_beat_gen: RTL
=================

# mwr_beat_gen

AXI4 write-data (W channel) beat generator for the memcopy write engine. Sits directly downstream of the write-engine control and address logic and drives the W channel toward the host bus. It emits exactly the number of beats the control logic computed, with a deterministic incrementing data pattern, address-consistent byte strobes and WLAST on every burst boundary. It signals completion once the final beat has been accepted.

## Interface
- DATA_WIDTH, 512, W-channel data width; fixed at 512 (64 byte lanes)
- clk  in  1  core clock; all logic on rising edge
- resetn  in  1  reset, asynchronous and active-low
- wr_engine_start  in  1  one-cycle start pulse; ignored unless state is IDLE
- total_wr_beat_count  in  40  total beats to send; valid from the cycle after wr_engine_start
- wr_len  in  8  AXI length per burst (beats per burst = wr_len+1); sampled on start
- wr_size  in  3  AXI size, bytes per beat = 2^wr_size (0..6); sampled on start
- wrap_mode  in  1  1 = data pattern restarts every wrap period; sampled on start
- wrap_len  in  4  bursts per wrap period minus 1; sampled on start
- wr_init_data  in  32  base pattern word; sampled on start
- m_axi_wdata  out  512  beat data
- m_axi_wstrb  out  64  byte strobes
- m_axi_wlast  out  1  last beat of burst
- m_axi_wvalid  out  1  beat valid
- m_axi_wready  in  1  slave ready
- wr_data_done  out  1  one-cycle pulse: all beats accepted (or zero-beat job finished)

## Operation
- FSM states: IDLE, LOAD, SEND, DONE.
- IDLE: on wr_engine_start, latch wr_len, wr_size, wrap_mode, wrap_len, wr_init_data, then go to LOAD.
- LOAD (1 cycle): load beats_left <= total_wr_beat_count; clear beat_in_burst, burst_in_wrap, data_idx (32 b), lane_off (6 b).
  - If total_wr_beat_count == 0, go to DONE; else go to SEND.
- SEND: m_axi_wvalid = 1. On handshake (wvalid && wready):
  - beats_left -= 1
  - data_idx += 1, mod 2^32
  - lane_off += 2^size, mod 64
  - beat_in_burst += 1, or cleared to 0 when wlast
  - On the final beat (beats_left == 1), go to DONE.
- DONE (1 cycle): wr_data_done = 1, then go to IDLE.
- Data: m_axi_wdata = 16 copies of (wr_init_data + data_idx), mod 2^32.
- Strobe:
  - Bytes lane_off .. lane_off + 2^size − 1 are set; all other bytes are clear.
  - size 6 gives all ones. Sizes 0..6 never cross 64.
  - This matches contiguous INCR addressing from a 64-byte-aligned target address. The control logic guarantees that alignment.
- m_axi_wlast = (beat_in_burst == wr_len) while in SEND.
- Wrap: when wrap_mode = 1 and a wlast handshake occurs:
  - If burst_in_wrap == wrap_len: clear burst_in_wrap, data_idx and lane_off, because the address wraps back to the base.
  - Otherwise: burst_in_wrap += 1.
  - When wrap_mode = 0, burst_in_wrap is unused.
- A partial final burst cannot occur, because total is a multiple of wr_len+1. If it does occur, no wlast is emitted on the tail. Verification treats that case as an error.

## Timing
- All outputs are registered or decoded from state and registers only. No combinational path from m_axi_wready to any output.
- Reset values:
  - m_axi_wvalid = 0, m_axi_wlast = 0, m_axi_wstrb = 0, m_axi_wdata = 0, wr_data_done = 0
  - state IDLE, all counters 0
- Latency:
  - Start pulse at cycle T.
  - LOAD at T+1.
  - First wvalid at T+2.
  - wr_data_done at the cycle after the final accepted beat.
  - Zero-beat job: wr_data_done at T+2.
- Handshake: once wvalid is high, wvalid, wdata, wstrb and wlast hold stable until accepted. Back-to-back beats are possible with no bubble, one beat per cycle while wready = 1.
- wr_engine_start in LOAD, SEND or DONE is ignored; the job in flight is unaffected.
- Asynchronous reset mid-burst: outputs drop to their reset values immediately, and the FSM returns to IDLE. No wlast or done is emitted.

## Test plan
- Basic job: len=3, size=6, init=0x100, total=8, wready=1.
  - Required: 8 beats on consecutive cycles.
  - Data words 0x100..0x107, wstrb all ones.
  - wlast on beats 4 and 8.
  - Done pulse one cycle after beat 8.
- Backpressure: same job with wready toggled pseudo-randomly.
  - Required: outputs stable while wvalid && !wready.
  - Identical beat sequence; done pulse after the final handshake.
- Narrow size: size=2, len=15, total=32.
  - Required: strobe walks 0x...000F, 0x...00F0, and so on, 4 bytes per beat, wrapping to byte 0 every 16 beats.
  - wlast on beats 16 and 32.
- Wrap: wrap_mode=1, wrap_len=1, len=1, total=8, init=0.
  - Required: data sequence 0,1,2,3,0,1,2,3; lane_off restarts with the data.
- Zero and ignore: start with total=0.
  - Required: no wvalid; done pulse at T+2.
  - Then a second start issued mid-SEND is ignored; beat count is unchanged.
- Reset mid-operation: assert resetn=0 at beat 3 of 8.
  - Required: wvalid=0 the same cycle.
  - After release, a new start runs a full job correctly from idx 0.

Source files
------------

// File: rtl/mwr_beat_gen.sv
// mwr_beat_gen: AXI4 W-channel beat generator for the memcopy write engine.
// Emits total_wr_beat_count beats of an incrementing 32-bit pattern replicated
// across the bus. Byte strobes follow contiguous INCR addressing from a
// 64-byte-aligned base. WLAST marks every burst boundary, and a one-cycle
// done pulse follows the final accepted beat.
module mwr_beat_gen #(
  parameter int DATA_WIDTH = 512
) (
  input  logic                    clk,
  input  logic                    resetn,
  input  logic                    wr_engine_start,
  input  logic [39:0]             total_wr_beat_count,
  input  logic [7:0]              wr_len,
  input  logic [2:0]              wr_size,
  input  logic                    wrap_mode,
  input  logic [3:0]              wrap_len,
  input  logic [31:0]             wr_init_data,
  output logic [DATA_WIDTH-1:0]   m_axi_wdata,
  output logic [DATA_WIDTH/8-1:0] m_axi_wstrb,
  output logic                    m_axi_wlast,
  output logic                    m_axi_wvalid,
  input  logic                    m_axi_wready,
  output logic                    wr_data_done
);

  localparam int NB = DATA_WIDTH / 8;   // byte lanes
  localparam int NW = DATA_WIDTH / 32;  // pattern word copies

  typedef enum logic [1:0] {IDLE, LOAD, SEND, DONE} state_t;

  state_t      state_q, state_d;

  // Job parameters, captured on start so upstream may change them mid-job.
  logic [7:0]  len_q;
  logic [2:0]  size_q;
  logic        wrap_q;
  logic [3:0]  wrap_len_q;
  logic [31:0] init_q;

  logic [39:0] beats_left_q;
  logic [7:0]  beat_in_burst_q;
  logic [3:0]  burst_in_wrap_q;
  logic [31:0] data_idx_q;
  logic [5:0]  lane_off_q;

  logic        send, hs, last;
  logic [7:0]  nbytes, strb_lo, strb_hi;
  logic [31:0] pat_word;

  assign send     = (state_q == SEND);
  assign hs       = send && m_axi_wready;
  assign last     = send && (beat_in_burst_q == len_q);
  // 8 bits holds 2^size for every legal size, and lane_off + 2^size cannot overflow.
  assign nbytes   = 8'd1 << size_q;
  assign strb_lo  = {2'b00, lane_off_q};
  assign strb_hi  = strb_lo + nbytes;
  assign pat_word = init_q + data_idx_q;

  // Outputs decode from state and registers only. Nothing depends on wready
  // combinationally, so the beat holds stable until it is accepted.
  assign m_axi_wvalid = send;
  assign m_axi_wlast  = last;
  assign wr_data_done = (state_q == DONE);

  for (genvar w = 0; w < NW; w++) begin : g_data
    assign m_axi_wdata[32*w +: 32] = send ? pat_word : 32'd0;
  end

  for (genvar b = 0; b < NB; b++) begin : g_strb
    assign m_axi_wstrb[b] = send && (8'(b) >= strb_lo) && (8'(b) < strb_hi);
  end

  // State register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state decode. A start pulse is honored only in IDLE.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (wr_engine_start) state_d = LOAD;
      LOAD: state_d = (total_wr_beat_count == 40'd0) ? DONE : SEND;
      SEND: if (hs && beats_left_q == 40'd1) state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Capture the job parameters on an accepted start.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      len_q      <= '0;
      size_q     <= '0;
      wrap_q     <= 1'b0;
      wrap_len_q <= '0;
      init_q     <= '0;
    end else if (state_q == IDLE && wr_engine_start) begin
      len_q      <= wr_len;
      size_q     <= wr_size;
      wrap_q     <= wrap_mode;
      wrap_len_q <= wrap_len;
      init_q     <= wr_init_data;
    end
  end

  // Beat, burst and pattern counters. They load in LOAD and advance per handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      beats_left_q    <= '0;
      beat_in_burst_q <= '0;
      burst_in_wrap_q <= '0;
      data_idx_q      <= '0;
      lane_off_q      <= '0;
    end else if (state_q == LOAD) begin
      beats_left_q    <= total_wr_beat_count;
      beat_in_burst_q <= '0;
      burst_in_wrap_q <= '0;
      data_idx_q      <= '0;
      lane_off_q      <= '0;
    end else if (hs) begin
      beats_left_q    <= beats_left_q - 40'd1;
      beat_in_burst_q <= last ? 8'd0 : beat_in_burst_q + 8'd1;
      if (wrap_q && last && burst_in_wrap_q == wrap_len_q) begin
        // The address wraps back to the base, so the pattern and the lanes restart.
        burst_in_wrap_q <= '0;
        data_idx_q      <= '0;
        lane_off_q      <= '0;
      end else begin
        if (wrap_q && last) burst_in_wrap_q <= burst_in_wrap_q + 4'd1;
        data_idx_q <= data_idx_q + 32'd1;
        lane_off_q <= lane_off_q + nbytes[5:0];
      end
    end
  end

endmodule
